// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake, load-use
// scoreboard, illegal-opcode flagging and a saturating hazard-stall counter.
module decode_stage #(
  parameter int unsigned INSN_W   = 32,
  parameter int unsigned OPC_W    = 5,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned IMM_W    = 17,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_alu,
  output logic              out_is_addi,
  output logic              out_is_sw,
  output logic              out_is_lw,
  output logic              out_is_illegal,
  output logic              out_DMwe,
  output logic              out_Rwe,
  output logic              out_Rwd,
  output logic              out_ALUinB,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_alu_op,
  output logic [DATA_W-1:0] out_imm,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned RD_LSB = INSN_W - OPC_W - REG_AW;
  localparam int unsigned RS_LSB = RD_LSB - REG_AW;
  localparam int unsigned RT_LSB = RS_LSB - REG_AW;

  localparam logic [OPC_W-1:0] OPC_ALU  = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OPC_SW   = OPC_W'(5'b00111);
  localparam logic [OPC_W-1:0] OPC_LW   = OPC_W'(5'b01000);

  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] rd_f, rs_f, rt_f;
  logic              dec_alu, dec_addi, dec_sw, dec_lw, dec_ill;
  logic [2:0]        src_use;
  logic [REG_AW-1:0] src_reg [3];
  logic              hazard;
  logic              accept, issue;

  logic [LOAD_LAT-1:0] sb_valid;
  logic [REG_AW-1:0]   sb_rd [LOAD_LAT];

  assign opc  = in_insn[INSN_W-1 -: OPC_W];
  assign rd_f = in_insn[RD_LSB +: REG_AW];
  assign rs_f = in_insn[RS_LSB +: REG_AW];
  assign rt_f = in_insn[RT_LSB +: REG_AW];

  // Opcode decode and the source registers each instruction type reads
  always_comb begin
    dec_alu    = (opc == OPC_ALU);
    dec_addi   = (opc == OPC_ADDI);
    dec_sw     = (opc == OPC_SW);
    dec_lw     = (opc == OPC_LW);
    dec_ill    = ~(dec_alu | dec_addi | dec_sw | dec_lw);
    src_use    = {dec_sw, dec_alu, ~dec_ill};
    src_reg[0] = rs_f;
    src_reg[1] = rt_f;
    src_reg[2] = rd_f;
  end

  // Load-use check against the held lw and every live scoreboard entry
  always_comb begin
    hazard = 1'b0;
    for (int unsigned s = 0; s < 3; s++) begin
      if (src_use[s] && (src_reg[s] != '0)) begin
        if (out_valid && out_is_lw && (out_rd == src_reg[s])) hazard = 1'b1;
        for (int unsigned e = 0; e < LOAD_LAT; e++) begin
          if (sb_valid[e] && (sb_rd[e] == src_reg[s])) hazard = 1'b1;
        end
      end
    end
    hazard = hazard & in_valid;
  end

  assign hazard_stall = hazard;
  assign in_ready     = reset_n & (~out_valid | out_ready) & ~hazard;
  assign accept       = in_valid & in_ready;
  assign issue        = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_is_alu     <= 1'b0;
      out_is_addi    <= 1'b0;
      out_is_sw      <= 1'b0;
      out_is_lw      <= 1'b0;
      out_is_illegal <= 1'b0;
      out_DMwe       <= 1'b0;
      out_Rwe        <= 1'b0;
      out_Rwd        <= 1'b0;
      out_ALUinB     <= 1'b0;
      out_rd         <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_shamt      <= '0;
      out_alu_op     <= '0;
      out_imm        <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_is_alu     <= dec_alu;
      out_is_addi    <= dec_addi;
      out_is_sw      <= dec_sw;
      out_is_lw      <= dec_lw;
      out_is_illegal <= dec_ill;
      out_DMwe       <= dec_sw;
      out_Rwe        <= dec_alu | dec_addi | dec_lw;
      out_Rwd        <= dec_lw;
      out_ALUinB     <= dec_addi | dec_sw | dec_lw;
      out_rd         <= rd_f;
      out_rs         <= rs_f;
      out_rt         <= rt_f;
      out_shamt      <= in_insn[11:7];
      out_alu_op     <= in_insn[6:2];
      out_imm        <= DATA_W'($signed(in_insn[IMM_W-1:0]));
    end else if (issue) begin
      out_valid      <= 1'b0;
    end
  end

  // Scoreboard ages every cycle; entries are born only when a lw issues
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_valid <= '0;
      for (int unsigned e = 0; e < LOAD_LAT; e++) sb_rd[e] <= '0;
    end else begin
      sb_valid[0] <= issue & out_is_lw & (out_rd != '0);
      sb_rd[0]    <= out_rd;
      for (int unsigned e = 1; e < LOAD_LAT; e++) begin
        sb_valid[e] <= sb_valid[e-1];
        sb_rd[e]    <= sb_rd[e-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (hazard && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a cycle-level
// reference model that tracks when each register's pending load completes.
module tb_decode_stage;

  localparam int unsigned LOAD_LAT = 2;
  localparam int unsigned CNT_W    = 3;
  localparam int          SAT      = 7;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_insn;
  logic        out_is_alu, out_is_addi, out_is_sw, out_is_lw, out_is_illegal;
  logic        out_DMwe, out_Rwe, out_Rwd, out_ALUinB;
  logic [4:0]  out_rd, out_rs, out_rt, out_shamt, out_alu_op;
  logic [31:0] out_imm;
  logic        hazard_stall;
  logic [CNT_W-1:0] stall_cycles;

  decode_stage #(.LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_alu(out_is_alu), .out_is_addi(out_is_addi), .out_is_sw(out_is_sw),
    .out_is_lw(out_is_lw), .out_is_illegal(out_is_illegal),
    .out_DMwe(out_DMwe), .out_Rwe(out_Rwe), .out_Rwd(out_Rwd), .out_ALUinB(out_ALUinB),
    .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_shamt(out_shamt), .out_alu_op(out_alu_op), .out_imm(out_imm),
    .hazard_stall(hazard_stall), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_valid, m_clear;
  logic [31:0] m_insn;
  int          busy_until [32];
  int          cyc, m_stalls, n_obs_issue;
  logic [31:0] sent_q [$];
  bit          obs_hz, obs_rdy;

  function automatic void model_reset();
    m_valid  = 1'b0;
    m_clear  = 1'b1;
    m_insn   = '0;
    m_stalls = 0;
    foreach (busy_until[r]) busy_until[r] = -100;
    sent_q.delete();
  endfunction

  function automatic logic [8:0] exp_ctrl(input logic [31:0] insn);
    case (insn[31:27])
      5'd0:    return 9'b1000_0_0100;
      5'd5:    return 9'b0100_0_0101;
      5'd7:    return 9'b0010_0_1001;
      5'd8:    return 9'b0001_0_0111;
      default: return 9'b0000_1_0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] insn);
    int v = int'(insn[16:0]);
    if (insn[16]) v -= 131072;
    return 32'(v);
  endfunction

  function automatic bit reads_reg(input logic [31:0] insn, input int r);
    case (insn[31:27])
      5'd0:       return (r == insn[21:17]) || (r == insn[16:12]);
      5'd5, 5'd8: return (r == insn[21:17]);
      5'd7:       return (r == insn[21:17]) || (r == insn[26:22]);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic bit m_haz(input logic [31:0] insn);
    for (int r = 1; r < 32; r++) begin
      if (reads_reg(insn, r) &&
          ((m_valid && m_insn[31:27] == 5'd8 && m_insn[26:22] == r) || cyc <= busy_until[r]))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    check("ctrl", {out_is_alu, out_is_addi, out_is_sw, out_is_lw, out_is_illegal,
                   out_DMwe, out_Rwe, out_Rwd, out_ALUinB}, m_clear ? 9'd0 : exp_ctrl(m_insn));
    check("fields", {out_rd, out_rs, out_rt, out_shamt, out_alu_op}, m_clear ? 25'd0 : m_insn[26:2]);
    check("imm", out_imm, m_clear ? 32'd0 : exp_imm(m_insn));
    check("stall_cycles", stall_cycles, (m_stalls > SAT) ? SAT : m_stalls);
  endtask

  // One clock: called at posedge+1 with inputs driven, returns at next posedge+1
  task automatic tick();
    bit hz, acc, iss;
    logic [31:0] exp_i;
    #4;
    obs_hz  = hazard_stall;
    obs_rdy = in_ready;
    hz = reset_n && in_valid && m_haz(in_insn);
    check("hazard_stall_c", obs_hz, hz);
    check("in_ready_c", obs_rdy, reset_n && (!m_valid || out_ready) && !hz);
    if (reset_n && out_valid && out_ready) begin
      n_obs_issue++;
      if (sent_q.size() == 0) check("issue_unexpected", 1, 0);
      else begin
        exp_i = sent_q.pop_front();
        check("issue_order", {out_rd, out_rs, out_rt, out_shamt, out_alu_op}, exp_i[26:2]);
      end
    end
    if (reset_n && in_valid && obs_rdy) sent_q.push_back(in_insn);
    @(posedge clock);
    if (!reset_n) model_reset();
    else begin
      iss = m_valid && out_ready;
      acc = in_valid && !hz && (!m_valid || out_ready);
      if (iss && m_insn[31:27] == 5'd8 && m_insn[26:22] != 5'd0)
        busy_until[m_insn[26:22]] = cyc + LOAD_LAT;
      if (acc) begin
        m_insn  = in_insn;
        m_valid = 1'b1;
        m_clear = 1'b0;
      end else if (iss) m_valid = 1'b0;
      if (hz) m_stalls++;
      cyc++;
    end
    #1 check_outputs();
  endtask

  task automatic load_use(input string tag, input logic [31:0] lw, input logic [31:0] add,
                          input int exp_stalls);
    int st = 0;
    bit done = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_insn   = lw;
    tick();
    in_insn = add;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (obs_hz) st++;
      if (obs_rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    check({tag, "_accepted"}, done, 1);
    check({tag, "_stall_len"}, st, exp_stalls);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] nolw_insn();
    logic [4:0] ops [4] = '{5'd0, 5'd5, 5'd7, 5'd31};
    return {ops[$urandom_range(0, 3)], 27'($urandom)};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [4:0] ops [5] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd0};
    logic [4:0] op = ops[$urandom_range(0, 4)];
    if ($urandom_range(0, 9) == 0) op = 5'($urandom);
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 12'($urandom)};
  endfunction

  initial begin
    logic [33:0] snap_f;
    logic [31:0] snap_i;
    int          sent, base;
    bit          pend;

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_insn   = 32'h2822_0005;
    out_ready = 1'b1;
    cyc = 0;
    n_obs_issue = 0;
    model_reset();
    #1;
    repeat (3) tick();
    reset_n = 1'b1;

    // addi r1,r2,-3
    in_insn = 32'h2845_FFFD;
    tick();
    check("addi_type", {out_is_addi, out_is_alu, out_is_sw, out_is_lw}, 4'b1000);
    check("addi_ctrl", {out_Rwe, out_ALUinB, out_DMwe}, 3'b110);
    check("addi_regs", {out_rd, out_rs}, {5'd1, 5'd2});
    check("addi_imm", out_imm, 32'hFFFF_FFFD);

    in_insn = {5'b11111, 27'($urandom)};
    tick();
    check("ill_flag", out_is_illegal, 1);
    check("ill_ctrl", {out_is_alu, out_is_addi, out_is_sw, out_is_lw,
                       out_DMwe, out_Rwe, out_Rwd, out_ALUinB}, 8'd0);
    check("ill_valid", out_valid, 1);
    in_valid = 1'b0;
    repeat (2) tick();

    // lw r5,0(r1) then add r6,r5,r7: blocked while held and LOAD_LAT cycles after issue
    load_use("lu", 32'h4142_0000, 32'h018A_7000, 1 + LOAD_LAT);
    check("lu_counter", stall_cycles, 1 + LOAD_LAT);
    load_use("lu_r0", 32'h4002_0000, 32'h0180_7000, 0);
    check("lu_r0_counter", stall_cycles, 1 + LOAD_LAT);

    // Backpressure then a 10-instruction stream
    base     = n_obs_issue;
    in_valid = 1'b1;
    in_insn  = nolw_insn();
    tick();
    sent = 1;
    out_ready = 1'b0;
    in_insn   = nolw_insn();
    snap_f = {out_is_alu, out_is_addi, out_is_sw, out_is_lw, out_is_illegal,
              out_rd, out_rs, out_rt, out_shamt, out_alu_op};
    snap_i = out_imm;
    repeat (4) begin
      tick();
      check("bp_in_ready", obs_rdy, 0);
    end
    check("bp_hold_fields", {out_is_alu, out_is_addi, out_is_sw, out_is_lw, out_is_illegal,
                             out_rd, out_rs, out_rt, out_shamt, out_alu_op}, snap_f);
    check("bp_hold_imm", out_imm, snap_i);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sent < 10; k++) begin
      tick();
      if (obs_rdy) begin
        sent++;
        in_insn = nolw_insn();
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("bp_issued", n_obs_issue - base, 10);

    // Saturation: a held lw with downstream stalled keeps the add blocked
    in_valid = 1'b1;
    in_insn  = 32'h4142_0000;
    tick();
    out_ready = 1'b0;
    in_insn   = 32'h018A_7000;
    repeat (10) tick();
    check("sat_count", stall_cycles, SAT);
    #3 reset_n = 1'b0;
    #1;
    check("arst_count", stall_cycles, 0);
    check("arst_valid", out_valid, 0);
    model_reset();
    @(posedge clock);
    #1;
    repeat (2) tick();
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Random traffic; fetch holds an offered instruction until accepted
    pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 9) < 8);
        if (in_valid) in_insn = rand_insn();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      pend = in_valid && !obs_rdy;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("drain_empty", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
